// File: rtl/seg_access_ctrl.sv
// seg_access_ctrl: initiator for the 512B data-memory segment; sequences address/data setup,
// a single registered write strobe, and 1-4 beat incrementing read bursts.
module seg_access_ctrl #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int SETUP_CYC = 1
) (
  input  logic              CLK_SAC,
  input  logic              RST_N_SAC,
  input  logic              REQ_VALID_SAC,
  output logic              REQ_READY_SAC,
  input  logic              REQ_WE_SAC,
  input  logic [ADDR_W-1:0] REQ_ADDR_SAC,
  input  logic [1:0]        REQ_LEN_SAC,
  input  logic [DATA_W-1:0] REQ_WDATA_SAC,
  output logic              RSP_VALID_SAC,
  input  logic              RSP_READY_SAC,
  output logic              RSP_WACK_SAC,
  output logic [DATA_W-1:0] RSP_RDATA_SAC,
  output logic [ADDR_W-1:0] ADDR_SEG,
  output logic [DATA_W-1:0] DATA_IN_SEG,
  output logic              WE_SEG,
  input  logic [DATA_W-1:0] DATA_OUT_SEG
);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, SAMPLE, RESP} state_t;
  localparam logic [1:0] SETUP_M1 = 2'(SETUP_CYC - 1);
  state_t state, state_nxt;
  logic op_we;
  logic [1:0] beats_left, setup_cnt;
  logic req_fire, rsp_fire, next_beat;
  assign REQ_READY_SAC = state == IDLE;
  assign req_fire = REQ_VALID_SAC && REQ_READY_SAC;
  assign rsp_fire = state == RESP && RSP_READY_SAC;
  assign next_beat = !op_we && beats_left != 2'd0;
  always_ff @(posedge CLK_SAC or negedge RST_N_SAC)
    if (!RST_N_SAC) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = req_fire ? SETUP : IDLE;
      SETUP:   state_nxt = setup_cnt != 2'd0 ? SETUP : (op_we ? STROBE : SAMPLE);
      STROBE:  state_nxt = HOLD;
      HOLD:    state_nxt = RESP;
      SAMPLE:  state_nxt = RESP;
      RESP:    state_nxt = !RSP_READY_SAC ? RESP : (next_beat ? SETUP : IDLE);
      default: state_nxt = IDLE;
    endcase
  end
  // strobe is a flop output decoded from next state, so it cannot glitch and
  // only rises/falls on edges where address and data are already stable
  always_ff @(posedge CLK_SAC or negedge RST_N_SAC)
    if (!RST_N_SAC) begin
      ADDR_SEG      <= '0;
      DATA_IN_SEG   <= '0;
      WE_SEG        <= 1'b0;
      RSP_VALID_SAC <= 1'b0;
      RSP_WACK_SAC  <= 1'b0;
      RSP_RDATA_SAC <= '0;
      op_we         <= 1'b0;
      beats_left    <= 2'd0;
      setup_cnt     <= 2'd0;
    end else begin
      WE_SEG <= state_nxt == STROBE;
      if (req_fire) begin
        ADDR_SEG    <= REQ_ADDR_SAC;
        DATA_IN_SEG <= REQ_WDATA_SAC;
        op_we       <= REQ_WE_SAC;
        beats_left  <= REQ_LEN_SAC;
        setup_cnt   <= SETUP_M1;
      end
      if (state == SETUP && setup_cnt != 2'd0) setup_cnt <= setup_cnt - 2'd1;
      if (state == HOLD || state == SAMPLE) begin
        RSP_VALID_SAC <= 1'b1;
        RSP_WACK_SAC  <= state == HOLD;
        RSP_RDATA_SAC <= state == HOLD ? '0 : DATA_OUT_SEG;
      end
      if (rsp_fire) begin
        RSP_VALID_SAC <= 1'b0;
        if (next_beat) begin
          ADDR_SEG   <= ADDR_SEG + 1'b1;
          beats_left <= beats_left - 2'd1;
          setup_cnt  <= SETUP_M1;
        end
      end
    end
endmodule
